// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command responder: operand width,
// opcode encodings and the packed response layout {carry, zero, result}.
package alu_pkg;

  localparam int WIDTH = 8;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  // One buffered response; 10 bits wide with WIDTH = 8.
  typedef struct packed {
    logic             carry;
    logic             zero;
    logic [WIDTH-1:0] result;
  } rsp_t;

  localparam int RSP_W = $bits(rsp_t);

endpackage

// File: rtl/alu_cmd_responder_if.sv
// Command and response channels of the ALU command responder.
// The master drives commands and rsp_ready; the slave is the responder.
// Build option: ALU_ACCUM_EN adds cmd_acc (use accumulator as operand A).
interface alu_cmd_responder_if #(parameter int DEPTH = 4);
  import alu_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [2:0]       cmd_op;
`ifdef ALU_ACCUM_EN
  logic             cmd_acc;
`endif
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_carry;
  logic             rsp_zero;
  logic [CW-1:0]    rsp_count;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
`ifdef ALU_ACCUM_EN
    output cmd_acc,
`endif
    input  cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_count
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
`ifdef ALU_ACCUM_EN
    input  cmd_acc,
`endif
    output cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_count
  );

endinterface

// File: rtl/alu_rsp_fifo.sv
// Generic synchronous FIFO with occupancy count. Head data is read
// combinationally from the read pointer; pointers wrap modulo DEPTH
// (DEPTH must be a power of 2). Reset is synchronous, active-high.
module alu_rsp_fifo #(
  parameter int DW    = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DW-1:0]            wdata,
  input  logic                     pop,
  output logic [DW-1:0]            rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_en;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign rdata = mem[rd_ptr];

  // Storage, pointers and occupancy update on every accepted push/pop.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would let later statements see new ones.
  // NOTE: the storage array is reset so the head reads as all-zero after
  // reset, which is what the response outputs must show.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_responder.sv
// Clocked command responder around an 8-bit combinational ALU. Commands
// are computed in the cycle they are accepted and the {carry, zero, result}
// responses are returned in order through a DEPTH-entry FIFO.
// Build option: ALU_ACCUM_EN adds an accumulator selectable as operand A.
module alu_cmd_responder #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  alu_cmd_responder_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH:0]   alu_wide;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  alu_pkg::rsp_t    rsp_in;
  alu_pkg::rsp_t    rsp_head;

  // cmd_ready depends only on stored occupancy, never on rsp_ready.
  assign bus.cmd_ready = !full;
  assign push          = bus.cmd_valid && !full;
  assign pop           = !empty && bus.rsp_ready;

`ifdef ALU_ACCUM_EN
  logic [WIDTH-1:0] acc_q;

  assign op_a = bus.cmd_acc ? acc_q : bus.cmd_a;

  // Accumulator captures every accepted result so accumulating commands chain.
  always_ff @(posedge clk) begin
    if (rst)       acc_q <= '0;
    else if (push) acc_q <= alu_res;
  end
`else
  assign op_a = bus.cmd_a;
`endif

  // ALU datapath: result and carry/borrow for the presented command.
  // NOTE: every output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    alu_wide  = '0;
    alu_res   = '0;
    alu_carry = 1'b0;
    case (bus.cmd_op)
      alu_pkg::OP_ADD: begin
        alu_wide  = {1'b0, op_a} + {1'b0, bus.cmd_b};
        alu_res   = alu_wide[WIDTH-1:0];
        alu_carry = alu_wide[WIDTH];
      end
      alu_pkg::OP_SUB: begin
        // Bit WIDTH of the 9-bit difference is the unsigned borrow.
        alu_wide  = {1'b0, op_a} - {1'b0, bus.cmd_b};
        alu_res   = alu_wide[WIDTH-1:0];
        alu_carry = alu_wide[WIDTH];
      end
      alu_pkg::OP_AND: alu_res = op_a & bus.cmd_b;
      alu_pkg::OP_OR:  alu_res = op_a | bus.cmd_b;
      alu_pkg::OP_XOR: alu_res = op_a ^ bus.cmd_b;
      alu_pkg::OP_SHL: begin
        alu_res   = {op_a[WIDTH-2:0], 1'b0};
        alu_carry = op_a[WIDTH-1];
      end
      alu_pkg::OP_SHR: begin
        alu_res   = {1'b0, op_a[WIDTH-1:1]};
        alu_carry = op_a[0];
      end
      alu_pkg::OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, (op_a < bus.cmd_b)};
      default:         alu_res = '0;
    endcase
  end

  assign rsp_in = {alu_carry, (alu_res == '0), alu_res};

  alu_rsp_fifo #(
    .DW    (alu_pkg::RSP_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (rsp_in),
    .pop   (pop),
    .rdata (rsp_head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign bus.rsp_valid  = !empty;
  assign bus.rsp_result = rsp_head.result;
  assign bus.rsp_carry  = rsp_head.carry;
  assign bus.rsp_zero   = rsp_head.zero;
  assign bus.rsp_count  = count;

endmodule
